// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width derivation, pointer wrap, and error-flag bit positions
// reused across FIFO variants.
package fifo_pkg;

  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;
  localparam int unsigned ERR_W       = 2;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// The array has no reset; stale contents are unreachable through the pointers.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CNT_W   = cnt_width(DEPTH),
  localparam int unsigned PTR_W   = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DATA_W-1:0] ram_rdata;
  logic push_acc, pop_acc, bypass, ovf_evt, udf_evt;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we     (push_acc),
    .waddr  (wr_ptr_q),
    .wdata  (wr_data),
    .raddr  (rd_ptr_q),
    .rdata  (ram_rdata)
  );

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign overflow     = err_q[ERR_OVF_BIT];
  assign underflow    = err_q[ERR_UDF_BIT];

  always_comb begin
`ifdef FIFO_FWFT_EN
    bypass  = 1'b0;
    udf_evt = pop && empty;
`else
    // Push+pop into an empty FIFO hands the word straight to rd_data.
    bypass  = push && pop && empty;
    udf_evt = pop && empty && !push;
`endif
    ovf_evt  = push && full && !pop;
    push_acc = push && (!full || pop) && !bypass;
    pop_acc  = pop && !empty;

    wr_ptr_d = push_acc ? PTR_W'(ptr_next(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? PTR_W'(ptr_next(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;

    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear first so an error in the same cycle still sets its flag.
    err_d = clr_err ? '0 : err_q;
    err_d[ERR_OVF_BIT] = err_d[ERR_OVF_BIT] | ovf_evt;
    err_d[ERR_UDF_BIT] = err_d[ERR_UDF_BIT] | udf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_data  = ram_rdata;
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (bypass) begin
      rd_data_d  = wr_data;
      rd_valid_d = 1'b1;
    end else if (pop_acc) begin
      rd_data_d  = ram_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags in its default registered-read build.
module tb_fifo_sync_flags;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AF    = 8;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_err;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  fifo_sync_flags #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .wr_data      (wr_data),
    .pop          (pop),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  task automatic check_all();
    chk("count",        32'(count),        32'(q.size()));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
    chk("rd_data",      32'(rd_data),      32'(m_rd_data));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
  endtask

  task automatic op(input logic p, input logic [DW-1:0] d, input logic pp, input logic c);
    int n;
    logic e, f;
    step++;
    push = p; wr_data = d; pop = pp; clr_err = c;
    @(posedge clk);
    n = q.size();
    e = (n == 0);
    f = (n == DEPTH);
    m_ovf = (m_ovf & ~c) | (p & f & ~pp);
    m_udf = (m_udf & ~c) | (pp & e & ~p);
    m_rd_valid = 1'b0;
    if (p && pp && e) begin
      m_rd_data  = d;
      m_rd_valid = 1'b1;
    end else begin
      if (pp && !e) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (p && (!f || pp)) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then overflow and clear.
    for (int i = 1; i <= 10; i++) op(1'b1, DW'(i), 1'b0, 1'b0);
    chk("full_after_10", 32'(full), 32'd1);
    op(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd10);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain in order, then one idle cycle.
    for (int i = 1; i <= 10; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last_pop_data", 32'(rd_data), 32'h0A);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    // Underflow, clear racing a new error, then real clear.
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow), 32'd1);
    op(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_sticky_vs_clr", 32'(underflow), 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1);

    // Bypass on push+pop while empty.
    op(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("bypass_data", 32'(rd_data), 32'h5A);
    chk("bypass_count", 32'(count), 32'd0);
    op(1'b0, 8'h00, 1'b0, 1'b0);

    // Wrap: burst, alternating traffic, burst into full, push+pop at full.
    for (int k = 0; k < 7; k++) op(1'b1, DW'(8'h20 + k), 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      if (i % 2 == 0) op(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      else            op(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int k = 0; k < 7; k++) op(1'b1, DW'(8'h60 + k), 1'b0, 1'b0);
    op(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_pushpop_no_ovf_extra", 32'(count), 32'd10);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) op(1'b0, 8'h00, 1'b1, 1'b0);
    op(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset with six words stored.
    for (int k = 0; k < 6; k++) op(1'b1, DW'(8'h90 + k), 1'b0, 1'b0);
    chk("count_before_rst", 32'(count), 32'd6);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fresh traffic after reset.
    for (int k = 0; k < 3; k++) op(1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_last", 32'(rd_data), 32'hC2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
